regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline
//  writeback (WB) stage and the multi-cycle mul/div unit (MDU). WB always has
//  priority; MDU writes are accepted through a valid/ready handshake.
//  A 32-entry scoreboard tracks registers with an MDU result still outstanding,
//  so decode can stall on RAW hazards. A starvation guard forces a WB bubble so
//  that a waiting MDU result cannot be blocked indefinitely.
// PARAMETERS
//  MAX_WAIT  8   cycles an MDU request may be refused before a WB bubble is forced (>=1)
//  CNT_W     4   width of the wait counter; must satisfy 2**CNT_W > MAX_WAIT
// PORTS
//  i_clk         in   1   clock; all state updates on the rising edge
//  i_rst         in   1   asynchronous active-high reset
//  i_pipe_we     in   1   WB write request (no backpressure)
//  i_pipe_waddr  in   5   WB destination register
//  i_pipe_wdata  in   32  WB write data
//  i_mdu_valid   in   1   MDU result valid
//  i_mdu_waddr   in   5   MDU destination register
//  i_mdu_wdata   in   32  MDU result
//  o_mdu_ready   out  1   MDU result accepted this cycle (when valid)
//  i_sb_set      in   1   decode issued an MDU op this cycle
//  i_sb_addr     in   5   destination register of that op
//  i_raddr1      in   5   decode source register 1 (scoreboard lookup)
//  i_raddr2      in   5   decode source register 2 (scoreboard lookup)
//  o_busy1       out  1   i_raddr1 has an MDU result outstanding
//  o_busy2       out  1   i_raddr2 has an MDU result outstanding
//  o_pipe_stall  out  1   request to hold WB: no WB write next cycle
//  o_err         out  1   sticky: WB wrote while o_pipe_stall was high
//  o_we          out  1   to register file write enable
//  o_waddr       out  5   to register file write address
//  o_wdata       out  32  to register file write data
// BEHAVIOUR
//  Reset: FSM=RUN, wait_cnt=0, pending=0, o_pipe_stall=0, o_err=0.
//   Combinational outputs with idle inputs: o_we=0, o_waddr=0, o_wdata=0.
//  Write-port mux (combinational, zero latency; the register file commits on the next edge):
//   - i_pipe_we=1: WB owns the port, o_mdu_ready=0.
//   - otherwise: o_mdu_ready=1; if i_mdu_valid, the MDU owns the port.
//   - No owner: o_we=0, o_waddr=0, o_wdata=0.
//   - Address 0: o_we is forced to 0, but the MDU handshake still completes.
//  Handshake: an MDU transfer occurs on an edge where i_mdu_valid && o_mdu_ready.
//   The MDU holds waddr/wdata stable while valid && !ready.
//  Scoreboard (pending[31:0]; bit 0 is always 0):
//   - i_sb_set && i_sb_addr!=0 sets pending[i_sb_addr].
//   - An MDU transfer clears pending[i_mdu_waddr].
//   - Set and clear to the same address in one cycle: set wins.
//   - Setting a bit that is already set leaves it set.
//   - o_busyN = pending[i_raddrN], combinational from current state (no bypass).
//  Starvation FSM:
//   - RUN: wait_cnt increments on each cycle with valid && !ready, and clears on a transfer.
//     When wait_cnt==MAX_WAIT-1 and the MDU is refused again -> FORCE.
//   - FORCE: o_pipe_stall=1 (registered, so asserted the first cycle after entry).
//     On an MDU transfer -> RUN, wait_cnt=0.
//     If i_mdu_valid drops -> RUN.
//   - While o_pipe_stall=1, WB must keep i_pipe_we=0. If WB writes anyway,
//     WB still wins and o_err sets (cleared only by reset).
//  Reset mid-operation: all pending bits are lost; no write is issued.
// STRUCTURE
//  Shared package: FSM state encodings (RUN/FORCE) and REG_ZERO=5'd0.
//  One natural sub-module: regfile_scoreboard (pending vector, set/clear, two lookups).
//  Mux and FSM stay in the top level.
// TESTING
//  1 WB only: pipe_we=1, waddr=5, wdata=32'hA5A5_0001 -> o_we=1, o_waddr=5, o_mdu_ready=0.
//  2 MDU only: mdu_valid=1, waddr=9, wdata=32'h1234 -> o_we=1, o_waddr=9, ready=1;
//    pending[9] set earlier clears, o_busy1 (raddr1=9) goes 1->0 after the edge.
//  3 Collision: both request for 3 cycles -> WB writes each cycle, MDU data held,
//    o_mdu_ready=0; WB idle on cycle 4 -> MDU write completes.
//  4 Starvation: MAX_WAIT=8, WB writes continuously -> o_pipe_stall=1 after 8 refusals;
//    bench drops pipe_we -> MDU transfer, stall deasserts on the next cycle.
//  5 Scoreboard edges: set and clear of addr 7 in the same cycle -> pending[7]=1;
//    sb_set addr 0 -> o_busy stays 0; MDU write to addr 0 -> o_we=0, ready=1.
//  6 Reset while pending=0x0000_0F00 and FSM=FORCE -> all zero, o_pipe_stall=0 immediately;
//    WB write during stall -> o_err=1 and stays set.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the starvation FSM encoding and the hard-wired zero register address.
package regfile_wr_arbiter_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FORCE = 1'b1
  } arb_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NUM_REGS = 32;

endpackage : regfile_wr_arbiter_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: one bit per architectural register with an MDU
// result still in flight, plus two combinational lookups for decode.
module regfile_scoreboard
  import regfile_wr_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_set,
  input  logic [4:0] i_set_addr,
  input  logic       i_clr,
  input  logic [4:0] i_clr_addr,
  input  logic [4:0] i_raddr1,
  input  logic [4:0] i_raddr2,
  output logic       o_busy1,
  output logic       o_busy2
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Set takes precedence over a same-cycle clear of the same register.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_d[gi] = 1'b0;
      end else begin : g_reg
        assign pending_d[gi] = (i_set && (i_set_addr == 5'(gi))) ||
                               (pending_q[gi] && !(i_clr && (i_clr_addr == 5'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign o_busy1 = pending_q[i_raddr1];
  assign o_busy2 = pending_q[i_raddr2];

endmodule : regfile_scoreboard

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port shared by the WB stage (priority) and the MDU
// (valid/ready), with a RAW scoreboard and a starvation guard that stalls WB.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pipe_we,
  input  logic [4:0]  i_pipe_waddr,
  input  logic [31:0] i_pipe_wdata,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_waddr,
  input  logic [31:0] i_mdu_wdata,
  output logic        o_mdu_ready,
  input  logic        i_sb_set,
  input  logic [4:0]  i_sb_addr,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic        o_busy1,
  output logic        o_busy2,
  output logic        o_pipe_stall,
  output logic        o_err,
  output logic        o_we,
  output logic [4:0]  o_waddr,
  output logic [31:0] o_wdata
);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              stall_q;
  logic              err_q;

  logic              mdu_ready;
  logic              mdu_xfer;
  logic              mdu_refused;
  logic              sel_we;
  logic [4:0]        sel_addr;
  logic [31:0]       sel_data;

  // Nothing is granted while reset is held, so no write leaks out mid-reset.
  assign mdu_ready   = !i_pipe_we && !i_rst;
  assign mdu_xfer    = i_mdu_valid && mdu_ready;
  assign mdu_refused = i_mdu_valid && !mdu_ready;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = REG_ZERO;
    sel_data = '0;
    if (i_pipe_we) begin
      sel_we   = 1'b1;
      sel_addr = i_pipe_waddr;
      sel_data = i_pipe_wdata;
    end else if (i_mdu_valid) begin
      sel_we   = 1'b1;
      sel_addr = i_mdu_waddr;
      sel_data = i_mdu_wdata;
    end
  end

  assign o_we        = sel_we && (sel_addr != REG_ZERO) && !i_rst;
  assign o_waddr     = sel_addr;
  assign o_wdata     = sel_data;
  assign o_mdu_ready = mdu_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (stall_q && i_pipe_we) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (mdu_xfer) begin
            wait_cnt_q <= '0;
          end else if (mdu_refused) begin
            if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
              state_q    <= ST_FORCE;
              stall_q    <= 1'b1;
              wait_cnt_q <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
        end
        ST_FORCE: begin
          // Leave once the waiting result drains or the MDU withdraws it.
          if (mdu_xfer || !i_mdu_valid) begin
            state_q    <= ST_RUN;
            stall_q    <= 1'b0;
            wait_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_pipe_stall = stall_q;
  assign o_err        = err_q;

  regfile_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (i_sb_set),
    .i_set_addr (i_sb_addr),
    .i_clr      (mdu_xfer),
    .i_clr_addr (i_mdu_waddr),
    .i_raddr1   (i_raddr1),
    .i_raddr2   (i_raddr2),
    .o_busy1    (o_busy1),
    .o_busy2    (o_busy2)
  );

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: expected register-file writes are queued when
// driven and matched by a negedge monitor; each scenario task checks inline.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_waddr = '0;
  logic [31:0] mdu_wdata = '0;
  logic        mdu_ready;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_addr = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        busy1, busy2, pipe_stall, err, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.MAX_WAIT(8), .CNT_W(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pipe_we    (pipe_we),
    .i_pipe_waddr (pipe_waddr),
    .i_pipe_wdata (pipe_wdata),
    .i_mdu_valid  (mdu_valid),
    .i_mdu_waddr  (mdu_waddr),
    .i_mdu_wdata  (mdu_wdata),
    .o_mdu_ready  (mdu_ready),
    .i_sb_set     (sb_set),
    .i_sb_addr    (sb_addr),
    .i_raddr1     (raddr1),
    .i_raddr2     (raddr2),
    .o_busy1      (busy1),
    .o_busy2      (busy2),
    .o_pipe_stall (pipe_stall),
    .o_err        (err),
    .o_we         (we),
    .o_waddr      (waddr),
    .o_wdata      (wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Every cycle with a granted write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (waddr !== e.a || wdata !== e.d) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   waddr, wdata, e.a, e.d);
        end else begin
          $display("write addr=%0d data=%h ok", waddr, wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    mdu_valid = 1'b0; mdu_waddr = '0; mdu_wdata = '0;
    sb_set = 1'b0; sb_addr = '0;
  endtask

  // Eight refused MDU cycles under continuous WB traffic; stall must stay low until the 8th edge.
  task automatic drive_refusals(input logic [4:0] ma, input logic [31:0] md);
    mdu_valid = 1'b1; mdu_waddr = ma; mdu_wdata = md;
    for (int i = 0; i < 8; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'hB000_0000 + i;
      push(5'd3, 32'hB000_0000 + i);
      #1;
      n_checks++;
      if (pipe_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_early: refusal %0d got stall=%b, required 0", i, pipe_stall);
      end
      step();
    end
    n_checks++;
    if (pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_assert: got stall=%b, required 1 after 8 refusals", pipe_stall);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port: got we=%b addr=%0d data=%h, required 0/0/0", we, waddr, wdata);
    end
    n_checks++;
    if (pipe_stall !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got stall=%b err=%b, required 0/0", pipe_stall, err);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ready=%b busy1=%b busy2=%b, required 1/0/0", mdu_ready, busy1, busy2);
    end
    step();
    $display("test_reset done");
  endtask

  task automatic test_wb_only();
    pipe_we = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hA5A5_0001;
    push(5'd5, 32'hA5A5_0001);
    #1;
    n_checks++;
    if (we !== 1'b1 || waddr !== 5'd5 || mdu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_only: got we=%b addr=%0d ready=%b, required 1/5/0", we, waddr, mdu_ready);
    end
    step();
    idle();
    $display("test_wb_only done");
  endtask

  task automatic test_mdu_only();
    sb_set = 1'b1; sb_addr = 5'd9;
    step();
    sb_set = 1'b0; raddr1 = 5'd9;
    #1;
    n_checks++;
    if (busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set9: got busy1=%b, required 1", busy1);
    end
    mdu_valid = 1'b1; mdu_waddr = 5'd9; mdu_wdata = 32'h0000_1234;
    push(5'd9, 32'h0000_1234);
    #1;
    n_checks++;
    if (we !== 1'b1 || waddr !== 5'd9 || mdu_ready !== 1'b1 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL mdu_only: got we=%b addr=%0d ready=%b busy1=%b, required 1/9/1/1",
               we, waddr, mdu_ready, busy1);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear9: got busy1=%b, required 0", busy1);
    end
    step();
    $display("test_mdu_only done");
  endtask

  task automatic test_collision();
    mdu_valid = 1'b1; mdu_waddr = 5'd14; mdu_wdata = 32'hCAFE_0014;
    for (int i = 0; i < 3; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'(6 + i); pipe_wdata = 32'hD000_0000 + i;
      push(5'(6 + i), 32'hD000_0000 + i);
      #1;
      n_checks++;
      if (mdu_ready !== 1'b0 || waddr !== 5'(6 + i)) begin
        n_fail++;
        $display("FAIL collision_wb: cycle %0d got ready=%b addr=%0d, required 0/%0d",
                 i, mdu_ready, waddr, 6 + i);
      end
      step();
    end
    pipe_we = 1'b0;
    push(5'd14, 32'hCAFE_0014);
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1 || we !== 1'b1 || waddr !== 5'd14) begin
      n_fail++;
      $display("FAIL collision_mdu: got ready=%b we=%b addr=%0d, required 1/1/14", mdu_ready, we, waddr);
    end
    step();
    idle();
    $display("test_collision done");
  endtask

  task automatic test_starvation();
    drive_refusals(5'd12, 32'h5555_000C);
    pipe_we = 1'b0;
    push(5'd12, 32'h5555_000C);
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1 || waddr !== 5'd12) begin
      n_fail++;
      $display("FAIL starve_xfer: got ready=%b addr=%0d, required 1/12", mdu_ready, waddr);
    end
    step();
    idle();
    n_checks++;
    if (pipe_stall !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_release: got stall=%b err=%b, required 0/0", pipe_stall, err);
    end
    step();
    $display("test_starvation done");
  endtask

  task automatic test_sb_edges();
    sb_set = 1'b1; sb_addr = 5'd7;
    mdu_valid = 1'b1; mdu_waddr = 5'd7; mdu_wdata = 32'h0000_0777;
    push(5'd7, 32'h0000_0777);
    raddr1 = 5'd7; raddr2 = 5'd7;
    step();
    idle();
    n_checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: got busy1=%b busy2=%b, required 1/1", busy1, busy2);
    end
    sb_set = 1'b1; sb_addr = 5'd7;
    step();
    sb_set = 1'b1; sb_addr = 5'd0; raddr1 = 5'd0;
    step();
    sb_set = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_addr0: got busy1=%b busy2=%b, required 0/1", busy1, busy2);
    end
    mdu_valid = 1'b1; mdu_waddr = 5'd0; mdu_wdata = 32'hDEAD_0000;
    #1;
    n_checks++;
    if (we !== 1'b0 || mdu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mdu_addr0: got we=%b ready=%b, required 0/1", we, mdu_ready);
    end
    step();
    mdu_waddr = 5'd7; mdu_wdata = 32'h0000_7007;
    push(5'd7, 32'h0000_7007);
    step();
    idle();
    n_checks++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear7: got busy2=%b, required 0", busy2);
    end
    step();
    $display("test_sb_edges done");
  endtask

  task automatic test_reset_mid();
    for (int i = 8; i < 12; i++) begin
      sb_set = 1'b1; sb_addr = 5'(i);
      step();
    end
    sb_set = 1'b0; raddr1 = 5'd8; raddr2 = 5'd11;
    #1;
    n_checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_f00: got busy1=%b busy2=%b, required 1/1", busy1, busy2);
    end
    drive_refusals(5'd20, 32'h2020_2020);
    rst = 1'b1;
    #1;
    n_checks++;
    if (pipe_stall !== 1'b0 || we !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got stall=%b we=%b busy1=%b busy2=%b, required 0/0/0/0",
               pipe_stall, we, busy1, busy2);
    end
    step();
    idle();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      raddr1 = 5'(r);
      #1;
      n_checks++;
      if (busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pend: reg %0d got busy=%b, required 0", r, busy1);
      end
    end
    step();
    drive_refusals(5'd21, 32'h2121_2121);
    pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'hEEEE_0004;
    push(5'd4, 32'hEEEE_0004);
    #1;
    n_checks++;
    if (we !== 1'b1 || waddr !== 5'd4 || mdu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_in_stall: got we=%b addr=%0d ready=%b, required 1/4/0", we, waddr, mdu_ready);
    end
    step();
    n_checks++;
    if (err !== 1'b1 || pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got err=%b stall=%b, required 1/1", err, pipe_stall);
    end
    pipe_we = 1'b0;
    push(5'd21, 32'h2121_2121);
    step();
    idle();
    repeat (3) step();
    n_checks++;
    if (err !== 1'b1 || pipe_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b stall=%b, required 1/0", err, pipe_stall);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_mdu_only();
    test_collision();
    test_starvation();
    test_sb_edges();
    test_reset_mid();
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d expected writes unseen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter
